// File: rtl/sha256_padder_if.sv
// Word-stream input and 512-bit block output of the SHA-256 message padder.
// A word moves on in_valid & in_ready, a block on blk_valid & blk_ready; the
// source holds its payload while valid is up and not yet accepted.
interface sha256_padder_if;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         blk_first;
    logic         blk_last;

    modport master (
        output in_data, in_valid, in_last, in_bytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );
endinterface

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit words into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit message bit length.
module sha256_padder #(
    parameter int LEN_CNT_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    sha256_padder_if.slave  bus,
    output logic [1:0]      state_dbg
);
    localparam logic [1:0]  ST_FILL  = 2'd0;
    localparam logic [1:0]  ST_EMIT  = 2'd1;
    localparam logic [1:0]  ST_XTRA  = 2'd2;
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    logic [1:0]           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [LEN_CNT_W-1:0] bitlen_q, bitlen_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic                 xtra_q, xtra_d;
    logic                 pad_pend_q, pad_pend_d;
    logic [31:0]          buf_q [16];
    logic [31:0]          buf_d [16];

    logic                 in_fire;
    logic                 blk_fire;
    logic [2:0]           n_bytes;
    logic [31:0]          last_word;
    logic [LEN_CNT_W-1:0] bitlen_inc;
    logic [LEN_CNT_W-1:0] bitlen_sum;
    logic [63:0]          len_next;
    logic [63:0]          len_cur;
    logic [4:0]           pad_pos;
    logic [511:0]         blk_flat;

    assign bus.in_ready  = (state_q == ST_FILL) && !rst;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign bus.blk_valid = (state_q == ST_EMIT);
    assign blk_fire      = bus.blk_valid && bus.blk_ready;
    assign bus.blk_first = bus.blk_valid && first_q;
    assign bus.blk_last  = bus.blk_valid && last_q;
    assign bus.blk_data  = blk_flat;
    assign state_dbg     = state_q;

    always_comb begin
        blk_flat = '0;
        for (int i = 0; i < 16; i++) begin
            blk_flat[511-32*i -: 32] = buf_q[i];
        end
    end

    // Final word: keep the top n bytes, drop the 0x80 marker right behind them.
    always_comb begin
        n_bytes = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
        case (n_bytes)
            3'd0:    last_word = PAD_WORD;
            3'd1:    last_word = {bus.in_data[31:24], 24'h80_0000};
            3'd2:    last_word = {bus.in_data[31:16], 16'h8000};
            3'd3:    last_word = {bus.in_data[31:8], 8'h80};
            default: last_word = bus.in_data;
        endcase
        if (bus.in_last) begin
            bitlen_inc = LEN_CNT_W'({n_bytes, 3'b000});
        end else begin
            bitlen_inc = LEN_CNT_W'(32);
        end
        bitlen_sum = bitlen_q + bitlen_inc;
        pad_pos    = {1'b0, idx_q} + ((n_bytes == 3'd4) ? 5'd1 : 5'd0);
        len_next   = '0;
        len_next[LEN_CNT_W-1:0] = bitlen_sum;
        len_cur    = '0;
        len_cur[LEN_CNT_W-1:0]  = bitlen_q;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bitlen_d   = bitlen_q;
        first_d    = first_q;
        last_d     = last_q;
        xtra_d     = xtra_q;
        pad_pend_d = pad_pend_q;
        buf_d      = buf_q;
        case (state_q)
            ST_FILL: begin
                if (in_fire) begin
                    bitlen_d = bitlen_sum;
                    if (!bus.in_last) begin
                        buf_d[idx_q] = bus.in_data;
                        idx_d        = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = ST_EMIT;
                            last_d  = 1'b0;
                            xtra_d  = 1'b0;
                        end
                    end else begin
                        buf_d[idx_q] = last_word;
                        // Slots beyond idx may hold an older block; clear them.
                        for (int j = 0; j < 16; j++) begin
                            if (j > int'(idx_q)) begin
                                buf_d[j] = (5'(j) == pad_pos) ? PAD_WORD : 32'h0;
                            end
                        end
                        state_d    = ST_EMIT;
                        pad_pend_d = (pad_pos == 5'd16);
                        if (pad_pos <= 5'd13) begin
                            buf_d[14] = len_next[63:32];
                            buf_d[15] = len_next[31:0];
                            last_d    = 1'b1;
                            xtra_d    = 1'b0;
                        end else begin
                            last_d    = 1'b0;
                            xtra_d    = 1'b1;
                        end
                    end
                end
            end
            ST_EMIT: begin
                if (blk_fire) begin
                    idx_d = 4'd0;
                    if (last_q) begin
                        bitlen_d = '0;
                        first_d  = 1'b1;
                        state_d  = ST_FILL;
                    end else begin
                        first_d  = 1'b0;
                        state_d  = xtra_q ? ST_XTRA : ST_FILL;
                    end
                end
            end
            ST_XTRA: begin
                // Overflow block: length only, plus the marker if it did not fit.
                for (int j = 0; j < 16; j++) begin
                    buf_d[j] = 32'h0;
                end
                if (pad_pend_q) begin
                    buf_d[0] = PAD_WORD;
                end
                buf_d[14]  = len_cur[63:32];
                buf_d[15]  = len_cur[31:0];
                last_d     = 1'b1;
                xtra_d     = 1'b0;
                pad_pend_d = 1'b0;
                state_d    = ST_EMIT;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FILL;
            idx_q      <= 4'd0;
            bitlen_q   <= '0;
            first_q    <= 1'b1;
            last_q     <= 1'b0;
            xtra_q     <= 1'b0;
            pad_pend_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bitlen_q   <= bitlen_d;
            first_q    <= first_d;
            last_q     <= last_d;
            xtra_q     <= xtra_d;
            pad_pend_q <= pad_pend_d;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end
endmodule
